// File: rtl/debounce_multi.sv
// Multi-channel input debouncer: per-channel synchroniser chain feeding a
// saturating stability counter, with level, edge-event, glitch and stable outputs.
module debounce_multi #(
  parameter int                NUM_CH          = 4,
  parameter int                CNT_W           = 8,
  parameter int                DEBOUNCE_CYCLES = 200,
  parameter int                SYNC_STAGES     = 2,
  parameter logic [NUM_CH-1:0] RESET_VAL       = {NUM_CH{1'b1}}
) (
  input  logic              clk,
  input  logic              w_sreset_counter,
  input  logic [NUM_CH-1:0] p_sigIn,
  input  logic              i_freeze,
  output logic [NUM_CH-1:0] p_Debounced,
  output logic [NUM_CH-1:0] o_rise,
  output logic [NUM_CH-1:0] o_fall,
  output logic [NUM_CH-1:0] o_glitch,
  output logic [NUM_CH-1:0] o_stable,
  output logic              o_any_event
);

  // Count value at which a differing sample commits the new level.
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] s;

  // The synchroniser keeps running through freeze so that a fresh sample
  // is ready the moment filtering resumes.
  always_ff @(posedge clk or posedge w_sreset_counter) begin
    if (w_sreset_counter) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= RESET_VAL;
      end
    end else begin
      sync_q[0] <= p_sigIn;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             deb_q;
    logic             rise_q;
    logic             fall_q;
    logic             glitch_q;
    logic             stable_q;

    // Counter only ever climbs towards CNT_TERM and is cleared on commit or
    // on any agreeing sample, so it cannot wrap.
    always_ff @(posedge clk or posedge w_sreset_counter) begin
      if (w_sreset_counter) begin
        cnt      <= '0;
        deb_q    <= RESET_VAL[ch];
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        glitch_q <= 1'b0;
        stable_q <= 1'b1;
      end else if (i_freeze) begin
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        glitch_q <= 1'b0;
      end else begin
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        glitch_q <= 1'b0;
        stable_q <= (s[ch] == deb_q);
        if (s[ch] == deb_q) begin
          cnt      <= '0;
          glitch_q <= (cnt != '0);
        end else if (cnt == CNT_TERM) begin
          cnt    <= '0;
          deb_q  <= s[ch];
          rise_q <= s[ch];
          fall_q <= ~s[ch];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign p_Debounced[ch] = deb_q;
    assign o_rise[ch]      = rise_q;
    assign o_fall[ch]      = fall_q;
    assign o_glitch[ch]    = glitch_q;
    assign o_stable[ch]    = stable_q;
  end

  always_ff @(posedge clk or posedge w_sreset_counter) begin
    if (w_sreset_counter) begin
      o_any_event <= 1'b0;
    end else begin
      o_any_event <= |(o_rise | o_fall);
    end
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed self-checking bench for debounce_multi with a 4-channel,
// 4-cycle debounce, 2-stage synchroniser configuration.
module tb_debounce_multi;

  logic       clk;
  logic       w_sreset_counter;
  logic [3:0] p_sigIn;
  logic       i_freeze;
  logic [3:0] p_Debounced;
  logic [3:0] o_rise;
  logic [3:0] o_fall;
  logic [3:0] o_glitch;
  logic [3:0] o_stable;
  logic       o_any_event;

  int compareCount  = 0;
  int mismatchCount = 0;

  debounce_multi #(
    .NUM_CH(4),
    .CNT_W(8),
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES(2),
    .RESET_VAL(4'hF)
  ) dut (
    .clk(clk),
    .w_sreset_counter(w_sreset_counter),
    .p_sigIn(p_sigIn),
    .i_freeze(i_freeze),
    .p_Debounced(p_Debounced),
    .o_rise(o_rise),
    .o_fall(o_fall),
    .o_glitch(o_glitch),
    .o_stable(o_stable),
    .o_any_event(o_any_event)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] sig, input logic frz);
    p_sigIn  = sig;
    i_freeze = frz;
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    w_sreset_counter = 1'b0;
    applyStimulus(4'hF, 1'b0);
    #2 w_sreset_counter = 1'b1;
    @(negedge clk);
    checkOutput("rst_deb",    8'(p_Debounced), 8'hF);
    checkOutput("rst_stable", 8'(o_stable),    8'hF);
    checkOutput("rst_pulses", {o_rise, o_fall}, 8'h00);
    checkOutput("rst_glitch", {3'b0, o_any_event, o_glitch}, 8'h00);
    stepCycles(2);
    w_sreset_counter = 1'b0;

    // Idle high: nothing may move.
    for (int i = 0; i < 20; i++) begin
      stepCycles(1);
      checkOutput("idle_pulses", {o_rise | o_fall, o_glitch}, 8'h00);
      checkOutput("idle_any", {7'b0, o_any_event}, 8'h00);
    end
    checkOutput("idle_deb",    8'(p_Debounced), 8'hF);
    checkOutput("idle_stable", 8'(o_stable),    8'hF);

    // Ch0 falls: commit on the 6th edge after the step.
    applyStimulus(4'hE, 1'b0);
    stepCycles(5);
    checkOutput("ch0_deb_early",  8'(p_Debounced), 8'hF);
    checkOutput("ch0_fall_early", 8'(o_fall),      8'h0);
    checkOutput("ch0_unstable",   8'(o_stable),    8'hE);
    stepCycles(1);
    checkOutput("ch0_deb",      8'(p_Debounced), 8'hE);
    checkOutput("ch0_fall",     8'(o_fall),      8'h1);
    checkOutput("ch0_any_lag",  {7'b0, o_any_event}, 8'h00);
    stepCycles(1);
    checkOutput("ch0_fall_once", 8'(o_fall), 8'h0);
    checkOutput("ch0_any",      {7'b0, o_any_event}, 8'h01);
    checkOutput("ch0_stable",   8'(o_stable), 8'hF);
    stepCycles(1);
    checkOutput("ch0_any_once", {7'b0, o_any_event}, 8'h00);

    // Ch1 low for three cycles only: aborted count, glitch pulse, no fall.
    applyStimulus(4'hC, 1'b0);
    stepCycles(3);
    applyStimulus(4'hE, 1'b0);
    stepCycles(2);
    checkOutput("ch1_glitch_early", 8'(o_glitch), 8'h0);
    checkOutput("ch1_fall_early",   8'(o_fall),   8'h0);
    stepCycles(1);
    checkOutput("ch1_glitch", 8'(o_glitch),    8'h2);
    checkOutput("ch1_nofall", 8'(o_fall),      8'h0);
    checkOutput("ch1_deb",    8'(p_Debounced), 8'hE);
    for (int i = 0; i < 6; i++) begin
      stepCycles(1);
      checkOutput("ch1_quiet", {o_fall, o_glitch}, 8'h00);
    end
    checkOutput("ch1_deb_hold", 8'(p_Debounced), 8'hE);

    // Ch2 and ch3 fall together.
    applyStimulus(4'h2, 1'b0);
    stepCycles(5);
    checkOutput("ch23_fall_early", 8'(o_fall), 8'h0);
    stepCycles(1);
    checkOutput("ch23_fall", 8'(o_fall),      8'hC);
    checkOutput("ch23_deb",  8'(p_Debounced), 8'h2);
    stepCycles(1);
    checkOutput("ch23_any",  {7'b0, o_any_event}, 8'h01);
    checkOutput("ch23_fall_once", 8'(o_fall), 8'h0);
    stepCycles(2);

    // Ch0 rises while frozen; commit only after release.
    applyStimulus(4'h3, 1'b1);
    for (int i = 0; i < 10; i++) begin
      stepCycles(1);
      checkOutput("frz_rise", 8'(o_rise),      8'h0);
      checkOutput("frz_deb",  8'(p_Debounced), 8'h2);
    end
    checkOutput("frz_stable", 8'(o_stable), 8'hF);
    applyStimulus(4'h3, 1'b0);
    stepCycles(3);
    checkOutput("thaw_rise_early", 8'(o_rise),   8'h0);
    checkOutput("thaw_stable",     8'(o_stable), 8'hE);
    stepCycles(1);
    checkOutput("thaw_rise", 8'(o_rise),      8'h1);
    checkOutput("thaw_deb",  8'(p_Debounced), 8'h3);
    stepCycles(2);

    // Reset mid-count on ch1 (count at 2).
    applyStimulus(4'h1, 1'b0);
    stepCycles(4);
    w_sreset_counter = 1'b1;
    #1;
    checkOutput("mid_rst_deb",    8'(p_Debounced), 8'hF);
    checkOutput("mid_rst_pulses", {o_rise | o_fall, o_glitch}, 8'h00);
    checkOutput("mid_rst_any",    {7'b0, o_any_event}, 8'h00);
    checkOutput("mid_rst_stable", 8'(o_stable), 8'hF);
    stepCycles(2);
    w_sreset_counter = 1'b0;
    stepCycles(5);
    checkOutput("post_rst_early", 8'(o_fall),      8'h0);
    checkOutput("post_rst_deb0",  8'(p_Debounced), 8'hF);
    stepCycles(1);
    checkOutput("post_rst_fall", 8'(o_fall),      8'hE);
    checkOutput("post_rst_deb",  8'(p_Debounced), 8'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
